// File: rtl/intersection_sensor_emulator_pkg.sv
// Shared lane definitions for the intersection sensor emulator.
// Lane FSM encoding and default timing constants.
package intersection_sensor_emulator_pkg;

    localparam int NUM_LANES   = 4;
    localparam int DEF_QW      = 4;
    localparam int DEF_STARTUP = 3;
    localparam int DEF_DEPART  = 2;
    localparam int DEF_CONG_ON = 6;
    localparam int DEF_CONG_OFF = 3;
    localparam int DEF_BOUNCE  = 4;

    typedef enum logic [1:0] {
        LANE_IDLE    = 2'd0,
        LANE_STARTUP = 2'd1,
        LANE_FLOW    = 2'd2
    } lane_state_e;

endpackage

// File: rtl/intersection_sensor_emulator_lane_queue_model.sv
// One lane: light FSM, vehicle queue, departure pacing,
// congestion hysteresis and presence-contact bounce.
module lane_queue_model
    import intersection_sensor_emulator_pkg::*;
#(
    parameter int QW             = DEF_QW,
    parameter int STARTUP_CYCLES = DEF_STARTUP,
    parameter int DEPART_CYCLES  = DEF_DEPART,
    parameter int CONG_ON        = DEF_CONG_ON,
    parameter int CONG_OFF       = DEF_CONG_OFF,
    parameter int BOUNCE_CYCLES  = DEF_BOUNCE
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          light_i,
    input  logic          arrival_i,
    output logic          raw_s1_o,
    output logic          raw_s5_o,
    output logic [QW-1:0] count_o,
    output logic          departed_o,
    output logic          overflow_o
);

    localparam int SW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam int PW = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
    localparam int BW = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam int BL = (BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0;
    localparam logic [SW-1:0] SLOAD = SW'(STARTUP_CYCLES - 1);
    localparam logic [PW-1:0] PLOAD = PW'(DEPART_CYCLES - 1);
    localparam logic [BW-1:0] BLOAD = BW'(BL);
    localparam logic [QW-1:0] QMAX  = '1;

    lane_state_e   state_q, state_d;
    logic [SW-1:0] start_q, start_d;
    logic [PW-1:0] pace_q, pace_d;
    logic [QW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          dep_q, dep_d;
    logic          ovf_q, ovf_d;
    logic          s5_q, s5_d;
    logic          tgt_q, tgt_d;
    logic          s1_q, s1_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LANE_IDLE;
            start_q <= '0;
            pace_q  <= '0;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            dep_q   <= 1'b0;
            ovf_q   <= 1'b0;
            s5_q    <= 1'b0;
            tgt_q   <= 1'b0;
            s1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            pace_q  <= pace_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            dep_q   <= dep_d;
            ovf_q   <= ovf_d;
            s5_q    <= s5_d;
            tgt_q   <= tgt_d;
            s1_q    <= s1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        pace_d  = pace_q;
        dep_d   = 1'b0;
        if (!light_i) begin
            state_d = LANE_IDLE;
            start_d = '0;
            pace_d  = '0;
        end else begin
            unique case (state_q)
                LANE_IDLE: begin
                    state_d = LANE_STARTUP;
                    start_d = SLOAD;
                end
                LANE_STARTUP: begin
                    if (start_q == '0) begin
                        state_d = LANE_FLOW;
                        pace_d  = '0;
                    end else begin
                        start_d = start_q - SW'(1);
                    end
                end
                LANE_FLOW: begin
                    if (pace_q == '0 && cnt_q != '0) begin
                        dep_d  = 1'b1;
                        pace_d = PLOAD;
                    end else if (pace_q != '0) begin
                        pace_d = pace_q - PW'(1);
                    end
                end
                default: state_d = LANE_IDLE;
            endcase
        end
    end

    // Simultaneous arrival and departure cancel; no overflow then.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (arrival_i && !dep_d) begin
            if (cnt_q == QMAX) ovf_d = 1'b1;
            else               cnt_d = cnt_q + QW'(1);
        end else if (!arrival_i && dep_d) begin
            cnt_d = cnt_q - QW'(1);
        end
    end

    always_comb begin
        s5_d = s5_q;
        if (int'(cnt_d) >= CONG_ON)       s5_d = 1'b1;
        else if (int'(cnt_d) <= CONG_OFF) s5_d = 1'b0;
    end

    // The first bounce cycle shows the new level, then alternates.
    always_comb begin
        tgt_d  = (cnt_d != '0);
        bcnt_d = bcnt_q;
        s1_d   = tgt_q;
        if (tgt_d != tgt_q) begin
            s1_d   = tgt_d;
            bcnt_d = BLOAD;
        end else if (bcnt_q != '0) begin
            s1_d   = ~s1_q;
            bcnt_d = bcnt_q - BW'(1);
        end
    end

    assign raw_s1_o   = s1_q;
    assign raw_s5_o   = s5_q;
    assign count_o    = cnt_q;
    assign departed_o = dep_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/intersection_sensor_emulator.sv
// Four-lane closed-loop intersection model driving raw sensor lines
// back into the traffic-light controller.
module intersection_sensor_emulator
    import intersection_sensor_emulator_pkg::*;
#(
    parameter int QW             = DEF_QW,
    parameter int STARTUP_CYCLES = DEF_STARTUP,
    parameter int DEPART_CYCLES  = DEF_DEPART,
    parameter int CONG_ON        = DEF_CONG_ON,
    parameter int CONG_OFF       = DEF_CONG_OFF,
    parameter int BOUNCE_CYCLES  = DEF_BOUNCE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_LANES-1:0]     traffic_lights,
    input  logic [NUM_LANES-1:0]     arrival,
    output logic [NUM_LANES-1:0]     raw_s1,
    output logic [NUM_LANES-1:0]     raw_s5,
    output logic [NUM_LANES*QW-1:0]  queue_count,
    output logic [NUM_LANES-1:0]     departed,
    output logic [NUM_LANES-1:0]     overflow
);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_queue_model #(
            .QW            (QW),
            .STARTUP_CYCLES(STARTUP_CYCLES),
            .DEPART_CYCLES (DEPART_CYCLES),
            .CONG_ON       (CONG_ON),
            .CONG_OFF      (CONG_OFF),
            .BOUNCE_CYCLES (BOUNCE_CYCLES)
        ) u_lane (
            .clk_i     (clk),
            .rst_i     (rst),
            .light_i   (traffic_lights[i]),
            .arrival_i (arrival[i]),
            .raw_s1_o  (raw_s1[i]),
            .raw_s5_o  (raw_s5[i]),
            .count_o   (queue_count[i*QW +: QW]),
            .departed_o(departed[i]),
            .overflow_o(overflow[i])
        );
    end

endmodule

// File: tb/tb_intersection_sensor_emulator.sv
// Scenario bench for the intersection sensor emulator with
// queued expectations for departures and contact waveforms.
module tb_intersection_sensor_emulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  traffic_lights;
    logic [3:0]  arrival;
    logic [3:0]  raw_s1;
    logic [3:0]  raw_s5;
    logic [15:0] queue_count;
    logic [3:0]  departed;
    logic [3:0]  overflow;

    int n_cmp = 0;
    int n_bad = 0;

    int   dep_k_q[$];
    int   dep_c_q[$];
    logic s1_q[$];

    intersection_sensor_emulator dut (
        .clk           (clk),
        .rst           (rst),
        .traffic_lights(traffic_lights),
        .arrival       (arrival),
        .raw_s1        (raw_s1),
        .raw_s5        (raw_s5),
        .queue_count   (queue_count),
        .departed      (departed),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [3:0] cnt(input int lane);
        return queue_count[lane*4 +: 4];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        traffic_lights = 4'b0;
        arrival = 4'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] lanes);
        arrival = lanes;
        tick();
        arrival = 4'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({raw_s1, raw_s5, queue_count, departed, overflow} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {raw_s1, raw_s5, queue_count, departed, overflow});
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            n_cmp++;
            if ({raw_s1, raw_s5, queue_count, departed, overflow} !== 32'h0) begin
                n_bad++;
                $display("FAIL idle_outputs cyc=%0d got=%h want=0", k,
                         {raw_s1, raw_s5, queue_count, departed, overflow});
            end
        end
    endtask

    task automatic test_drain();
        int ek;
        int ec;
        logic es;
        for (int k = 1; k <= 7; k++) begin
            pulse(4'b0001);
            n_cmp++;
            if (cnt(0) !== 4'(k) || raw_s5[0] !== (k >= 6) || departed !== 4'b0) begin
                n_bad++;
                $display("FAIL red_arrival k=%0d cnt=%0d s5=%b dep=%b want cnt=%0d s5=%b dep=0",
                         k, cnt(0), raw_s5[0], departed, k, (k >= 6));
            end
        end
        for (int j = 0; j < 7; j++) begin
            dep_k_q.push_back(5 + 2 * j);
            dep_c_q.push_back(6 - j);
        end
        for (int k = 1; k <= 30; k++) begin
            if (k < 17)       s1_q.push_back(1'b1);
            else if (k <= 20) s1_q.push_back((k % 2) == 0);
            else              s1_q.push_back(1'b0);
        end
        traffic_lights = 4'b0001;
        for (int k = 1; k <= 30; k++) begin
            tick();
            es = s1_q.pop_front();
            n_cmp++;
            if (raw_s1[0] !== es) begin
                n_bad++;
                $display("FAIL drain_s1 k=%0d got=%b want=%b", k, raw_s1[0], es);
            end
            if (departed[0] === 1'b1) begin
                n_cmp++;
                if (dep_k_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL drain_extra_dep k=%0d got=1 want=0", k);
                end else begin
                    ek = dep_k_q.pop_front();
                    ec = dep_c_q.pop_front();
                    if (k != ek || cnt(0) !== 4'(ec)) begin
                        n_bad++;
                        $display("FAIL drain_dep k=%0d cnt=%0d want k=%0d cnt=%0d",
                                 k, cnt(0), ek, ec);
                    end
                    n_cmp++;
                    if (raw_s5[0] !== (ec >= 4)) begin
                        n_bad++;
                        $display("FAIL drain_s5 cnt=%0d got=%b want=%b",
                                 ec, raw_s5[0], (ec >= 4));
                    end
                end
            end
        end
        n_cmp++;
        if (dep_k_q.size() != 0 || cnt(0) !== 4'd0) begin
            n_bad++;
            $display("FAIL drain_done missing=%0d cnt=%0d want missing=0 cnt=0",
                     dep_k_q.size(), cnt(0));
        end
        dep_k_q.delete();
        dep_c_q.delete();
        traffic_lights = 4'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < 5; k++) pulse(4'b0100);
        traffic_lights = 4'b0100;
        for (int k = 0; k < 4; k++) tick();
        n_cmp++;
        if (departed !== 4'b0 || cnt(2) !== 4'd5) begin
            n_bad++;
            $display("FAIL simul_pre dep=%b cnt=%0d want dep=0 cnt=5", departed, cnt(2));
        end
        arrival = 4'b0100;
        tick();
        arrival = 4'b0;
        n_cmp++;
        if (departed[2] !== 1'b1 || cnt(2) !== 4'd5 || overflow !== 4'b0) begin
            n_bad++;
            $display("FAIL simul dep=%b cnt=%0d ovf=%b want dep=1 cnt=5 ovf=0",
                     departed[2], cnt(2), overflow);
        end
        traffic_lights = 4'b0;
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            pulse(4'b1000);
            n_cmp++;
            if (cnt(3) !== 4'((k > 15) ? 15 : k) || overflow[3] !== (k == 16)) begin
                n_bad++;
                $display("FAIL overflow k=%0d cnt=%0d ovf=%b want cnt=%0d ovf=%b",
                         k, cnt(3), overflow[3], (k > 15) ? 15 : k, (k == 16));
            end
        end
        for (int k = 0; k < 5; k++) tick();
        n_cmp++;
        if (overflow[3] !== 1'b1 || cnt(3) !== 4'd15) begin
            n_bad++;
            $display("FAIL overflow_sticky ovf=%b cnt=%0d want ovf=1 cnt=15",
                     overflow[3], cnt(3));
        end
    endtask

    task automatic test_light_drop();
        int first;
        pulse(4'b0010);
        pulse(4'b0010);
        traffic_lights = 4'b0010;
        tick();
        tick();
        traffic_lights = 4'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_cmp++;
            if (departed[1] !== 1'b0 || cnt(1) !== 4'd2) begin
                n_bad++;
                $display("FAIL drop dep=%b cnt=%0d want dep=0 cnt=2", departed[1], cnt(1));
            end
        end
        traffic_lights = 4'b0010;
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (departed[1] === 1'b1 && first < 0) first = k;
        end
        n_cmp++;
        if (first != 5 || cnt(1) !== 4'd0) begin
            n_bad++;
            $display("FAIL regreen first_dep=%0d cnt=%0d want first_dep=5 cnt=0",
                     first, cnt(1));
        end
        traffic_lights = 4'b0;
        tick();
    endtask

    task automatic test_reset_mid_flow();
        logic es;
        for (int k = 0; k < 10; k++) pulse(4'b0001);
        traffic_lights = 4'b0001;
        for (int k = 0; k < 6; k++) tick();
        n_cmp++;
        if (cnt(0) !== 4'd9 || overflow[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset cnt=%0d ovf3=%b want cnt=9 ovf3=1", cnt(0), overflow[3]);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({raw_s1, raw_s5, queue_count, departed, overflow} !== 32'h0) begin
            n_bad++;
            $display("FAIL mid_reset got=%h want=0",
                     {raw_s1, raw_s5, queue_count, departed, overflow});
        end
        rst = 1'b0;
        traffic_lights = 4'b0;
        tick();
        s1_q.push_back(1'b1);
        s1_q.push_back(1'b0);
        s1_q.push_back(1'b1);
        s1_q.push_back(1'b0);
        s1_q.push_back(1'b1);
        s1_q.push_back(1'b1);
        s1_q.push_back(1'b1);
        arrival = 4'b0100;
        tick();
        arrival = 4'b0;
        for (int k = 0; k < 7; k++) begin
            es = s1_q.pop_front();
            n_cmp++;
            if (raw_s1 !== {1'b0, es, 2'b00}) begin
                n_bad++;
                $display("FAIL bounce k=%0d got=%b want=%b", k, raw_s1, {1'b0, es, 2'b00});
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        traffic_lights = 4'b0;
        arrival = 4'b0;
        test_reset();
        test_drain();
        test_simultaneous();
        test_overflow();
        test_light_drop();
        test_reset_mid_flow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
